// File: rtl/adc_pkg.sv
// Shared widths, channel count and LED bar constants for the ADC averaging path.
package adc_pkg;
  localparam int ADC_W        = 12;
  localparam int CH_W         = 3;
  localparam int NUM_CH       = 8;
  localparam int LED_N        = 8;
  localparam int LED_STEP     = 512;
  localparam int AVG_LOG2_MAX = 4;
  localparam int SUM_W        = ADC_W + AVG_LOG2_MAX;

  // Block average by right shift; the result always fits in ADC_W bits.
  function automatic logic [ADC_W-1:0] avg_trunc(input logic [SUM_W-1:0] sum,
                                                 input int unsigned log2);
    return ADC_W'(sum >> log2);
  endfunction
endpackage

// File: rtl/adc_led_bar.sv
// Registered thermometer bar: bit i lit when the value exceeds i*LED_STEP.
module adc_led_bar
  import adc_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [ADC_W-1:0] iVAL,
  output logic [LED_N-1:0] oLED
);
  logic [LED_N-1:0] w_bar;
  logic [LED_N-1:0] r_led;

  always_comb begin
    w_bar = '0;
    for (int i = 0; i < LED_N; i++) begin
      w_bar[i] = (iVAL > ADC_W'(i * LED_STEP));
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_led <= '0;
    end else begin
      r_led <= w_bar;
    end
  end

  assign oLED = r_led;
endmodule

// File: rtl/adc_ch_avg.sv
// Per-channel block averager for tagged ADC samples, with a result bank and an LED bar
// for one selectable channel. One sample per cycle, average strobed one cycle after the last.
module adc_ch_avg
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID,
  input  logic [ADC_W-1:0] iSAMPLE,
  input  logic [CH_W-1:0]  iSCH,
  input  logic             iCLR,
  input  logic [CH_W-1:0]  iDISP_CH,
  output logic             oAVG_VALID,
  output logic [ADC_W-1:0] oAVG,
  output logic [CH_W-1:0]  oAVG_CH,
  output logic [LED_N-1:0] oLED
);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] r_acc  [NUM_CH];
  logic [CNT_W-1:0] r_cnt  [NUM_CH];
  logic [ADC_W-1:0] r_bank [NUM_CH];
  logic             r_avg_vld;
  logic [ADC_W-1:0] r_avg;
  logic [CH_W-1:0]  r_avg_ch;

  logic [ACC_W-1:0] w_sum;
  logic             w_last;
  logic [ADC_W-1:0] w_avg;
  logic [ADC_W-1:0] w_disp;

  assign w_sum  = r_acc[iSCH] + ACC_W'(iSAMPLE);
  assign w_last = (r_cnt[iSCH] == CNT_LAST);
  assign w_avg  = avg_trunc(SUM_W'(w_sum), AVG_LOG2);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i]  <= '0;
        r_cnt[i]  <= '0;
        r_bank[i] <= '0;
      end
      r_avg_vld <= 1'b0;
      r_avg     <= '0;
      r_avg_ch  <= '0;
    end else if (iCLR) begin
      // Clear outranks a coincident sample, even a block-closing one.
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
      r_avg_vld <= 1'b0;
    end else begin
      r_avg_vld <= 1'b0;
      if (iVALID) begin
        if (w_last) begin
          r_acc[iSCH]  <= '0;
          r_cnt[iSCH]  <= '0;
          r_bank[iSCH] <= w_avg;
          r_avg        <= w_avg;
          r_avg_ch     <= iSCH;
          r_avg_vld    <= 1'b1;
        end else begin
          r_acc[iSCH] <= w_sum;
          r_cnt[iSCH] <= r_cnt[iSCH] + CNT_W'(1);
        end
      end
    end
  end

  assign w_disp = r_bank[iDISP_CH];

  adc_led_bar u_led_bar (
    .iCLK (iCLK),
    .iRST (iRST),
    .iVAL (w_disp),
    .oLED (oLED)
  );

  assign oAVG_VALID = r_avg_vld;
  assign oAVG       = r_avg;
  assign oAVG_CH    = r_avg_ch;
endmodule

// File: doc/adc_ch_avg.md
Name: adc_ch_avg

Overview:
Downstream consumer of the serial ADC controller. It takes the 12-bit conversion results, each tagged with its 3-bit channel number. For each of 8 channels it accumulates a block of 2^AVG_LOG2 samples, emits the block average as a one-cycle strobe, and stores it in a per-channel result bank. It also drives the 8-LED bar graph for one selectable channel, replacing the raw top-8-bit LED display.

Parameters:
AVG_LOG2, 2, log2 of samples per average; legal range 0..4; 0 passes each sample straight through.

Ports:
iCLK  in  1  system clock; all state changes on its rising edge.
iRST  in  1  asynchronous active-low reset.
iVALID  in  1  one-cycle strobe: iSAMPLE/iSCH are valid this cycle.
iSAMPLE  in  12  unsigned conversion result.
iSCH  in  3  channel that iSAMPLE belongs to.
iCLR  in  1  synchronous clear of all accumulators and sample counters.
iDISP_CH  in  3  channel shown on oLED.
oAVG_VALID  out  1  one-cycle strobe: a new average is on oAVG/oAVG_CH.
oAVG  out  12  block average, truncated.
oAVG_CH  out  3  channel of oAVG.
oLED  out  8  thermometer bar of the stored average for iDISP_CH.

Behaviour:
- Reset (iRST low, asynchronous) clears all of the following to 0 and holds them while low: acc[0..7], cnt[0..7], bank[0..7], oAVG_VALID, oAVG, oAVG_CH, oLED.
- Accumulator width: 12+AVG_LOG2 bits. Max sum 4095*2^AVG_LOG2 always fits; no saturation is needed.
- Counter width: max(AVG_LOG2,1) bits. Only the addressed channel's counter advances; it wraps after the final sample.
- iVALID=1, iCLR=0, ch=iSCH:
  - If cnt[ch] < 2^AVG_LOG2-1: acc[ch] <= acc[ch]+iSAMPLE; cnt[ch] <= cnt[ch]+1.
  - Final sample (cnt[ch] == 2^AVG_LOG2-1): compute sum = acc[ch]+iSAMPLE; avg = sum >> AVG_LOG2, truncated.
  - On that edge: oAVG <= avg; oAVG_CH <= ch; oAVG_VALID <= 1; bank[ch] <= avg; acc[ch] <= 0; cnt[ch] <= 0.
- Latency: oAVG_VALID asserts exactly 1 cycle after the final-sample iVALID and stays high for 1 cycle. Otherwise oAVG_VALID <= 0.
- oAVG/oAVG_CH hold their last values between strobes.
- Back-to-back iVALID on any channels, including the same channel every cycle, is fully supported: 1 sample/cycle, no stall, no ready signal.
- AVG_LOG2=0: every iVALID is a final sample, so oAVG = iSAMPLE one cycle later.
- iCLR=1: all acc and cnt <= 0; bank and oAVG/oAVG_CH are unchanged; oAVG_VALID <= 0.
- iCLR and iVALID in the same cycle: clear wins and the sample is dropped, even if it would have been a final sample.
- LED bar: oLED is registered with 1-cycle latency from bank/iDISP_CH. Bit i is set iff bank[iDISP_CH] > i*512, for i = 0..7.
  - bank=0 gives 8'h00; bank=4095 gives 8'hFF.
  - A bank write and a display read of the same channel in one cycle: oLED reflects the new bank value one cycle after the write edge, i.e. 2 cycles after the final iVALID.
- Reset mid-block discards partial sums; the next block after reset starts at cnt=0.

Decomposition:
- Shared package adc_pkg holds:
  - ADC_W=12, CH_W=3, NUM_CH=8.
  - LED_N=8 and LED_STEP=512.
  - A function avg_trunc(sum, log2).
- One natural sub-module, adc_led_bar: a registered 12-bit to 8-bit thermometer comparator with its own iCLK/iRST. It is reusable by other display paths.
- Accumulator/counter arrays stay in the top module.

Test Plan:
1. AVG_LOG2=2; ch1 receives samples 100,200,300,400 on consecutive cycles -> one cycle after the 400 cycle, oAVG_VALID=1, oAVG=250, oAVG_CH=1; no strobe earlier.
2. Interleave ch0 {4095 x4} with ch7 {1,1,1,2}, alternating cycles -> ch0 gives 4095 (no overflow) and ch7 gives 1 (truncation of 5>>2). Each strobe comes 1 cycle after its own final sample, in the correct order.
3. Send 3 samples to ch2, pulse iCLR, then send 10,20,30,40 -> oAVG=25 only after the 4 post-clear samples. Also: iCLR coincident with a final sample -> no strobe, and bank[2] is unchanged.
4. bank[5]=2000 with iDISP_CH=5 -> oLED=8'h0F. Switch iDISP_CH to 3 with bank[3]=0 -> oLED=8'h00 one cycle later. A 4095 average -> 8'hFF.
5. Assert iRST low asynchronously mid-block (between clock edges) -> all outputs read 0 immediately. After release, a full 4-sample block is required before the first strobe.
6. AVG_LOG2=0 build; sample 1234 on ch6 -> next cycle oAVG=1234, oAVG_CH=6, oAVG_VALID=1; continuous iVALID gives a strobe every cycle.
